// File: rtl/mavg_channel_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : mavg_channel_scheduler_if
// Purpose  : Bundles the multi-channel sample request side and the tagged
//            result side of the shared moving-average engine.
// Signals  : in_valid/in_data/in_ready - per-channel sample handshake
//            out_valid/out_ready       - result handshake
//            out_data/out_ch/out_primed - running sum, channel tag, window full
// Modports : master - sample producer / result consumer
//            slave  - the moving-average engine
// Revision : 1.0 - initial release
// ============================================================================
interface mavg_channel_scheduler_if #(
  parameter int NCH          = 4,
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 18
);
  localparam int C_CW = $clog2(NCH);

  logic [NCH-1:0]             in_valid;
  logic [NCH*INPUT_WIDTH-1:0] in_data;
  logic [NCH-1:0]             in_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUTPUT_WIDTH-1:0]    out_data;
  logic [C_CW-1:0]            out_ch;
  logic                       out_primed;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_primed
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_primed
  );
endinterface
`default_nettype wire

// File: rtl/mavg_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mavg_channel_scheduler
// Purpose  : Moving-average engine time-shared between NCH channels. A
//            round-robin arbiter picks one requesting channel per sample, a
//            3-state FSM (IDLE/CALC/OUT) runs one add/subtract update of that
//            channel's running sum, and the result is offered with its
//            channel tag on a valid/ready port.
// Ports    : clk   - system clock
//            nrst  - asynchronous active-low reset
//            clear - synchronous flush of all channel state
//            bus   - sample requests and tagged results (slave modport)
// Revision : 1.0 - initial release
// ============================================================================
module mavg_channel_scheduler #(
  parameter int NCH          = 4,
  parameter int INPUT_WIDTH  = 16,
  parameter int ORDER        = 4,
  parameter int OUTPUT_WIDTH = 18
) (
  input wire logic clk,
  input wire logic nrst,
  input wire logic clear,
  mavg_channel_scheduler_if.slave bus
);
  localparam int C_CW = $clog2(NCH);
  localparam int C_PW = $clog2(ORDER);
  localparam int C_FW = $clog2(ORDER + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [C_CW-1:0]         rr_q, rr_d;
  logic [C_CW-1:0]         gch_q, gch_d;
  logic [INPUT_WIDTH-1:0]  sample_q, sample_d;
  logic [INPUT_WIDTH-1:0]  hist_q [NCH][ORDER];
  logic [INPUT_WIDTH-1:0]  hist_d [NCH][ORDER];
  logic [C_PW-1:0]         ptr_q [NCH];
  logic [C_PW-1:0]         ptr_d [NCH];
  logic [OUTPUT_WIDTH-1:0] sum_q [NCH];
  logic [OUTPUT_WIDTH-1:0] sum_d [NCH];
  logic [C_FW-1:0]         fill_q [NCH];
  logic [C_FW-1:0]         fill_d [NCH];
  logic                    out_valid_q, out_valid_d;
  logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [C_CW-1:0]         out_ch_q, out_ch_d;
  logic                    out_primed_q, out_primed_d;

  logic                    w_found;
  logic [C_CW-1:0]         w_grant;
  logic                    w_accept;
  logic [NCH-1:0]          w_in_ready;
  logic [INPUT_WIDTH-1:0]  w_old;
  logic [OUTPUT_WIDTH-1:0] w_sum_new;
  logic [C_FW-1:0]         w_fill_new;

  // Round-robin search starting at rr_q; iterating downward lets the
  // closest requester to rr_q overwrite farther ones.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_grant = '0;
    idx     = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NCH;
      if (bus.in_valid[idx]) begin
        w_found = 1'b1;
        w_grant = idx[C_CW-1:0];
      end
    end
  end

  // Accept is suppressed during clear and while reset is asserted so no
  // handshake can complete on a cycle whose state update is discarded.
  assign w_accept = (state_q == ST_IDLE) && w_found && !clear && nrst;

  always_comb begin
    w_in_ready = '0;
    if (w_accept) w_in_ready[w_grant] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gch_d        = gch_q;
    sample_d     = sample_q;
    hist_d       = hist_q;
    ptr_d        = ptr_q;
    sum_d        = sum_q;
    fill_d       = fill_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_primed_d = out_primed_q;
    w_old        = '0;
    w_sum_new    = '0;
    w_fill_new   = '0;

    if (clear) begin
      state_d      = ST_IDLE;
      rr_d         = '0;
      gch_d        = '0;
      sample_d     = '0;
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      out_ch_d     = '0;
      out_primed_d = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        ptr_d[c]  = '0;
        sum_d[c]  = '0;
        fill_d[c] = '0;
        for (int s = 0; s < ORDER; s++) hist_d[c][s] = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            sample_d = bus.in_data[int'(w_grant)*INPUT_WIDTH +: INPUT_WIDTH];
            gch_d    = w_grant;
            rr_d     = (w_grant == C_CW'(NCH - 1)) ? '0 : w_grant + 1'b1;
            state_d  = ST_CALC;
          end
        end
        ST_CALC: begin
          // Slots not yet written hold 0, so warm-up sums are partial sums.
          w_old      = hist_q[gch_q][ptr_q[gch_q]];
          w_sum_new  = sum_q[gch_q] + OUTPUT_WIDTH'(sample_q) - OUTPUT_WIDTH'(w_old);
          w_fill_new = (fill_q[gch_q] == C_FW'(ORDER)) ? fill_q[gch_q] : fill_q[gch_q] + 1'b1;
          hist_d[gch_q][ptr_q[gch_q]] = sample_q;
          ptr_d[gch_q]  = ptr_q[gch_q] + 1'b1;  // ORDER is a power of two
          sum_d[gch_q]  = w_sum_new;
          fill_d[gch_q] = w_fill_new;
          out_data_d    = w_sum_new;
          out_ch_d      = gch_q;
          out_primed_d  = (w_fill_new == C_FW'(ORDER));
          out_valid_d   = 1'b1;
          state_d       = ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      rr_q         <= '0;
      gch_q        <= '0;
      sample_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_primed_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        ptr_q[c]  <= '0;
        sum_q[c]  <= '0;
        fill_q[c] <= '0;
        for (int s = 0; s < ORDER; s++) hist_q[c][s] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gch_q        <= gch_d;
      sample_q     <= sample_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_primed_q <= out_primed_d;
      hist_q       <= hist_d;
      ptr_q        <= ptr_d;
      sum_q        <= sum_d;
      fill_q       <= fill_d;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.out_primed = out_primed_q;
endmodule
`default_nettype wire

// File: tb/tb_mavg_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mavg_channel_scheduler
// Purpose  : Self-checking bench for mavg_channel_scheduler. Directed stimulus
//            with hand-computed expected sums queued at each accept; a
//            separate monitor pops and compares every delivered result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mavg_channel_scheduler;
  localparam int NCH = 4;
  localparam int IW  = 16;
  localparam int ORD = 4;
  localparam int OW  = 18;

  logic clk = 1'b0;
  logic nrst;
  logic clear;
  always #5 clk = ~clk;

  mavg_channel_scheduler_if #(.NCH(NCH), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

  mavg_channel_scheduler #(.NCH(NCH), .INPUT_WIDTH(IW), .ORDER(ORD), .OUTPUT_WIDTH(OW)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    int          ch;
    logic [OW-1:0] data;
    logic        primed;
    int          acc;
  } exp_t;

  exp_t vec[$];
  exp_t sb[$];
  logic [IW-1:0] din [NCH];
  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void add(int ch, int data, bit primed);
    exp_t e;
    e.ch = ch;
    e.data = OW'(data);
    e.primed = primed;
    e.acc = 0;
    vec.push_back(e);
  endfunction

  // Move the next hand-computed expectation onto the scoreboard at accept.
  function automatic void issue(int ch_seen);
    exp_t e;
    if (vec.size() == 0) begin
      n_vec++; n_miss++;
      $display("FAIL issue: accept on ch %0d with no vector queued", ch_seen);
    end else begin
      e = vec.pop_front();
      chk("grant_ch", ch_seen, e.ch);
      e.acc = cyc;
      sb.push_back(e);
    end
  endfunction

  task automatic set_inputs(input logic [NCH-1:0] mask);
    bus.in_valid = mask;
    for (int i = 0; i < NCH; i++) bus.in_data[i*IW +: IW] = din[i];
  endtask

  function automatic int onehot_idx(logic [NCH-1:0] v);
    int r = -1;
    for (int i = 0; i < NCH; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic drive_n(input logic [NCH-1:0] mask, input int n);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 200) begin
      @(negedge clk); #1;
      set_inputs(mask);
      #1;
      if ((bus.in_ready & bus.in_valid) != '0) begin
        issue(onehot_idx(bus.in_ready));
        got++;
      end
      guard++;
    end
    if (got < n) begin
      n_vec++; n_miss++;
      $display("FAIL drive_timeout: accepted %0d, want %0d", got, n);
    end
    @(negedge clk); #1;
    set_inputs('0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL drain: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk); #1 clear = 1'b1;
    @(negedge clk); #1 clear = 1'b0;
  endtask

  task automatic wait_out_valid();
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
  endtask

  // Monitor: latency on each rising out_valid, contents on each handshake.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk); #3;
      if (bus.out_valid && !prev) begin
        if (sb.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_result: ch %0d data 0x%0h, want no result", bus.out_ch, bus.out_data);
        end else begin
          chk("latency", cyc - sb[0].acc, 2);
        end
      end
      if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_ch", bus.out_ch, e.ch);
        chk("out_primed", bus.out_primed, e.primed);
      end
      if (bus.in_ready != '0) chk("in_ready_onehot", $countones(bus.in_ready), 1);
      prev = bus.out_valid;
    end
  end

  initial begin : stim
    int exp1 [8] = '{1, 3, 6, 10, 14, 18, 22, 26};
    int exp5 [6] = '{32'h0FFFF, 32'h1FFFE, 32'h2FFFD, 32'h3FFFC, 32'h3FFFC, 32'h3FFFC};
    nrst = 1'b0;
    clear = 1'b0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) din[i] = '0;

    // Reset state, with requests present to show in_ready is held off.
    repeat (2) @(negedge clk);
    #1 bus.in_valid = '1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ch", bus.out_ch, 0);
    chk("rst_out_primed", bus.out_primed, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    @(negedge clk); #1;
    bus.in_valid = '0;
    nrst = 1'b1;

    // Single channel warm-up and steady-state sliding window.
    for (int k = 1; k <= 8; k++) begin
      din[0] = IW'(k);
      add(0, exp1[k-1], k >= 4);
      drive_n(4'b0001, 1);
    end
    wait_drain();

    // Two channels alternating; histories stay separate.
    pulse_clear();
    din[0] = 16'd10;
    din[2] = 16'd20;
    add(0, 10, 0); add(2, 20, 0);
    add(0, 20, 0); add(2, 40, 0);
    add(0, 30, 0); add(2, 60, 0);
    add(0, 40, 1); add(2, 80, 1);
    add(0, 40, 1); add(2, 80, 1);
    drive_n(4'b0101, 10);
    wait_drain();

    // Backpressure: result held, all channels blocked, re-grant after release.
    pulse_clear();
    bus.out_ready = 1'b0;
    din[0] = 16'd7;
    din[1] = 16'd9;
    add(0, 7, 0);
    add(1, 9, 0);
    @(negedge clk); #1;
    set_inputs(4'b0011);
    #1;
    chk("bp_first_grant", bus.in_ready, 4'b0001);
    issue(onehot_idx(bus.in_ready));
    @(negedge clk); #1;
    set_inputs(4'b0010);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_data", bus.out_data, 7);
      chk("bp_out_ch", bus.out_ch, 0);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    @(negedge clk); #1;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_hs", bus.in_ready, 0);
    @(negedge clk); #2;
    chk("bp_regrant", bus.in_ready, 4'b0010);
    issue(onehot_idx(bus.in_ready));
    @(negedge clk); #1;
    set_inputs('0);
    wait_drain();

    // Clear flushes history; a clear on a ready cycle blocks the accept.
    pulse_clear();
    din[1] = 16'd3;
    add(1, 3, 0); add(1, 6, 0); add(1, 9, 0);
    for (int k = 0; k < 3; k++) drive_n(4'b0010, 1);
    wait_drain();
    @(negedge clk); #1;
    din[1] = 16'd77;
    set_inputs(4'b0010);
    clear = 1'b1;
    #1;
    chk("clear_blocks_ready", bus.in_ready, 0);
    @(negedge clk); #1;
    clear = 1'b0;
    set_inputs('0);
    repeat (4) @(negedge clk);
    din[1] = 16'd5;
    add(1, 5, 0);
    drive_n(4'b0010, 1);
    wait_drain();

    // Full-scale samples: largest sum, no wrap.
    din[3] = 16'hFFFF;
    for (int k = 0; k < 6; k++) begin
      add(3, exp5[k], k >= 3);
      drive_n(4'b1000, 1);
    end
    wait_drain();

    // Reset while a result is held; sums restart afterwards.
    din[0] = 16'd100;
    add(0, 100, 0);
    drive_n(4'b0001, 1);
    wait_drain();
    bus.out_ready = 1'b0;
    din[2] = 16'd4;
    add(2, 4, 0);
    drive_n(4'b0100, 1);
    wait_out_valid();
    chk("pre_rst_out_valid", bus.out_valid, 1);
    @(negedge clk); #1;
    din[0] = 16'd1;
    set_inputs(4'b1111);
    nrst = 1'b0;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_in_ready", bus.in_ready, 0);
    chk("async_rst_out_data", bus.out_data, 0);
    sb.delete();
    @(negedge clk); #1;
    nrst = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_grant", bus.in_ready, 4'b0001);
    add(0, 1, 0);
    issue(onehot_idx(bus.in_ready));
    @(negedge clk); #1;
    set_inputs('0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/mavg_channel_scheduler.md
Name: mavg_channel_scheduler

Overview:
Time-multiplexed moving-average engine shared between NCH sample requesters. A round-robin arbiter grants one channel per sample. An FSM sequences a single add/subtract datapath that updates that channel's running sum over its last ORDER samples. Each result is presented on a valid/ready output port tagged with its channel number. It sits between the multi-channel ADC front-end and downstream consumers, and replaces one filter instance per channel.

Parameters:
NCH, 4, number of requesting channels (>=2)
INPUT_WIDTH, 16, unsigned sample width
ORDER, 4, window length; power of two, >=2
OUTPUT_WIDTH, 18, running-sum width; must be >= INPUT_WIDTH+$clog2(ORDER)

Ports:
clk  in  1  system clock
nrst  in  1  reset; asynchronous, active-low
clear  in  1  synchronous flush of all channel state
in_valid  in  NCH  per-channel sample valid
in_data  in  NCH*INPUT_WIDTH  channel i sample at [i*INPUT_WIDTH +: INPUT_WIDTH]
in_ready  out  NCH  per-channel accept; at most one bit high
out_valid  out  1  result valid
out_ready  in  1  consumer accept
out_data  out  OUTPUT_WIDTH  running sum of the last ORDER samples of out_ch
out_ch  out  $clog2(NCH)  channel of current result
out_primed  out  1  1 when the window holds ORDER real samples

Behaviour:
- State per channel: history array of ORDER samples, write pointer, running sum, fill counter (0..ORDER, saturating).
- Reset (nrst=0, async): FSM=IDLE; all history, sums, pointers and fill counters = 0; rr pointer = 0; outputs in_ready=0, out_valid=0, out_data=0, out_ch=0, out_primed=0.
- FSM IDLE:
  - Round-robin grant among in_valid, searching from rr pointer upward with wrap (after reset, channel 0 has highest priority).
  - in_ready[g] = 1 combinationally, only in IDLE, only for the granted g with in_valid[g]=1.
  - On the accept cycle: latch sample and g; rr pointer <= g+1 mod NCH; go to CALC.
  - No valid requests -> stay in IDLE.
- FSM CALC (1 cycle):
  - sum_g <= sum_g + new - hist_g[ptr_g]; hist_g[ptr_g] <= new; ptr_g <= ptr_g+1 mod ORDER; fill_g <= min(fill_g+1, ORDER).
  - Register out_data=new sum, out_ch=g, out_primed=(updated fill==ORDER); go to OUT.
- FSM OUT:
  - out_valid=1. out_data/out_ch/out_primed held stable while out_ready=0.
  - out_valid&&out_ready -> out_valid=0 next cycle, back to IDLE.
- Latency: accept at cycle N -> out_valid at N+2. Peak throughput is one sample per 3 cycles with out_ready held high.
- in_ready is all-zero outside IDLE; backpressure propagates to every channel.
- Arithmetic: unsigned, OUTPUT_WIDTH bits. Unfilled slots read 0, so warm-up sums equal the partial sum. The sum is bounded by ORDER*(2^INPUT_WIDTH-1), so it never wraps.
- in_valid held low while granted-channel data changes is irrelevant; only the accept cycle's data is used.
- clear=1: highest priority after reset.
  - Forces in_ready=0 that cycle, so any coincident accept is aborted.
  - Next cycle: all channel state and rr pointer = 0, FSM=IDLE, out_valid=0. A pending unaccepted result is discarded.
- Reset asserted mid-operation: immediate return to reset values. An in-flight result is lost.

Test Plan:
- Single channel 0, samples 1..8 back-to-back, out_ready=1 -> out_data 1,3,6,10,14,18,22,26, out_ch=0, out_primed=0,0,0,1,1,1,1,1. Each result appears 2 cycles after its accept.
- Channels 0 and 2 hold in_valid=1 with constant data 10 and 20 -> grants alternate 0,2,0,2. Channel-2 sums are 20,40,60,80(primed),80. Channels never mix history.
- After first result, hold out_ready=0 for 5 cycles -> out_valid stays 1, out_data/out_ch stable, in_ready=0 for all channels. Release -> handshake completes, next grant 1 cycle later.
- Channel 1 fed 3,3,3 then clear pulse, then sample 5 -> result 5, out_primed=0, out_ch=1. A clear coinciding with an in_ready cycle -> that sample is not accepted.
- Channel 3 fed 0xFFFF six times -> final out_data=0x3FFFC, out_primed=1, no wrap.
- Assert nrst=0 while in OUT -> out_valid=0 and in_ready=0 asynchronously. After release, channel 0 is granted first and its sums restart from 0.
